fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the MIPS pipeline. Owns the program counter and drives instruction memory through a req/ack handshake. Writes fetched instructions into the IF/ID pipeline register with stall and redirect (branch/jump) support. Sits upstream of decode; redirect targets come back from branch/jump resolution.

Parameters:
N, 32, datapath/address width
RESET_PC, 32'h0040_0000, first fetch address (ROM base)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_i  input  1  downstream hazard stall; IF/ID must hold
redirect_valid_i  input  1  branch/jump taken this cycle
redirect_pc_i  input  N  redirect target
imem_req_o  output  1  fetch request
imem_addr_o  output  N  fetch address, stable while request pending
imem_rdata_i  input  N  instruction word, valid when ack=1
imem_ack_i  input  1  memory completes request (same cycle or later)
pc_o  output  N  current PC register
if_id_instr_o  output  N  IF/ID instruction
if_id_pc4_o  output  N  IF/ID PC+4 of that instruction
if_id_valid_o  output  1  IF/ID holds a real instruction
fetch_busy_o  output  1  state is WAIT or HOLD

Behaviour:
- Reset (reset=1 at edge): pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, state=FETCH, discard=0, pending target=0. imem_req_o forced 0 while reset=1. Reset mid-WAIT abandons the request; a late ack in FETCH with req=0 is ignored.
- imem_addr_o = pc always. Redirect targets have bits [1:0] forced to 00. PC+4 wraps modulo 2^N.
- States FETCH, WAIT, HOLD.
- FETCH:
  - imem_req_o = !stall_i.
  - req & ack: completion.
  - req & !ack: go WAIT.
  - req=0: nothing issued; pc holds.
- WAIT:
  - imem_req_o=1 regardless of stall; addr held.
  - On ack: completion.
- Completion without redirect or discard:
  - pc <= pc+4.
  - If stall_i=0: if_id <= {rdata, pc+4, valid=1}; go FETCH.
  - If stall_i=1: capture {rdata, pc+4} in hold buffer; IF/ID unchanged; go HOLD.
- HOLD:
  - imem_req_o=0.
  - When stall_i=0: if_id <= hold buffer, valid=1; go FETCH.
- stall_i=1 with no completion or redirect: IF/ID fully holds.
- IF/ID with stall_i=0 and nothing delivered: valid<=0, instr<=0 (bubble); pc4 may hold.
- Redirect (redirect_valid_i=1) has priority over stall_i:
  - IF/ID always flushed: valid<=0, instr<=0.
  - FETCH, no outstanding request, or ack in the same cycle: returned word dropped; pc <= target; stay FETCH.
  - WAIT without ack: store target as pending, discard<=1; stay WAIT with old address.
  - HOLD: buffer dropped; pc <= target; go FETCH.
- Discarded ack (WAIT, discard=1):
  - Instruction dropped; pc <= pending target; discard<=0; go FETCH.
  - A redirect in that same cycle supersedes pending: pc <= redirect_pc_i.
- A second redirect while discard=1 overwrites pending.
- if_id_pc4_o is always the fetched address +4, never the post-redirect PC.

Test Plan:
- Reset then zero-wait memory (ack=req, rdata=addr^32'hFFFF) -> imem_addr 0x400000, 0x400004, 0x400008 on consecutive cycles; if_id_pc4 = 0x400004, 0x400008; valid=1 from the second cycle.
- Memory ack delayed 3 cycles -> addr held at 0x400000 through WAIT; fetch_busy=1; single IF/ID write with pc4=0x400004; no duplicate request.
- stall_i=1 for 2 cycles while ack arrives in WAIT -> HOLD entered; IF/ID unchanged; on release IF/ID gets buffered word; pc already 0x400004; next req at 0x400004.
- Redirect to 0x400103 while request outstanding -> addr stays until ack; acked word dropped (valid stays 0); next fetch addr 0x400100.
- Redirect and stall_i=1 same cycle in FETCH -> IF/ID valid=0, instr=0; pc=target; req held 0 until stall clears.
- pc=0xFFFFFFFC fetched -> pc wraps to 0x00000000; if_id_pc4=0x00000000; reset asserted mid-WAIT -> pc=0x400000, valid=0 next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory over req/ack,
// and fills the IF/ID register with stall, hold-buffer and redirect handling.
module fetch_stage #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = 32'h0040_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_i,
  input  logic         redirect_valid_i,
  input  logic [N-1:0] redirect_pc_i,
  output logic         imem_req_o,
  output logic [N-1:0] imem_addr_o,
  input  logic [N-1:0] imem_rdata_i,
  input  logic         imem_ack_i,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] if_id_instr_o,
  output logic [N-1:0] if_id_pc4_o,
  output logic         if_id_valid_o,
  output logic         fetch_busy_o
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] pend_q, pend_d;
  logic         discard_q, discard_d;
  logic [N-1:0] hold_instr_q, hold_instr_d;
  logic [N-1:0] hold_pc4_q, hold_pc4_d;
  logic [N-1:0] if_id_instr_q, if_id_instr_d;
  logic [N-1:0] if_id_pc4_q, if_id_pc4_d;
  logic         if_id_valid_q, if_id_valid_d;

  logic [N-1:0] pc_plus4;
  logic [N-1:0] target;
  logic         req;
  logic         complete;

  assign pc_plus4 = pc_q + N'(4);
  assign target   = {redirect_pc_i[N-1:2], 2'b00};

  always_comb begin
    req = 1'b0;
    case (state_q)
      S_FETCH: req = !stall_i;
      S_WAIT:  req = 1'b1;
      default: req = 1'b0;
    endcase
    if (reset) req = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    discard_d     = discard_q;
    hold_instr_d  = hold_instr_q;
    hold_pc4_d    = hold_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    complete      = 1'b0;

    // Bubble when decode is free to advance; flush on any redirect.
    if (!stall_i || redirect_valid_i) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = '0;
    end

    case (state_q)
      S_FETCH: begin
        if (req) begin
          if (imem_ack_i) begin
            if (redirect_valid_i) pc_d = target;
            else                  complete = 1'b1;
          end else begin
            // A redirect racing an unacked request must still let it drain.
            state_d = S_WAIT;
            if (redirect_valid_i) begin
              discard_d = 1'b1;
              pend_d    = target;
            end
          end
        end else if (redirect_valid_i) begin
          pc_d = target;
        end
      end
      S_WAIT: begin
        if (imem_ack_i) begin
          state_d   = S_FETCH;
          discard_d = 1'b0;
          if (redirect_valid_i) pc_d = target;
          else if (discard_q)   pc_d = pend_q;
          else                  complete = 1'b1;
        end else if (redirect_valid_i) begin
          discard_d = 1'b1;
          pend_d    = target;
        end
      end
      S_HOLD: begin
        if (redirect_valid_i) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (!stall_i) begin
          if_id_instr_d = hold_instr_q;
          if_id_pc4_d   = hold_pc4_q;
          if_id_valid_d = 1'b1;
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (complete) begin
      pc_d = pc_plus4;
      if (!stall_i) begin
        if_id_instr_d = imem_rdata_i;
        if_id_pc4_d   = pc_plus4;
        if_id_valid_d = 1'b1;
        state_d       = S_FETCH;
      end else begin
        hold_instr_d = imem_rdata_i;
        hold_pc4_d   = pc_plus4;
        state_d      = S_HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      pend_q        <= '0;
      discard_q     <= 1'b0;
      hold_instr_q  <= '0;
      hold_pc4_q    <= '0;
      if_id_instr_q <= '0;
      if_id_pc4_q   <= '0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      discard_q     <= discard_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc4_q    <= hold_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_pc4_o   = if_id_pc4_q;
  assign if_id_valid_o = if_id_valid_q;
  assign fetch_busy_o  = (state_q == S_WAIT) || (state_q == S_HOLD);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: variable-latency memory, random stalls,
// redirects and resets, checked against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          NCYC     = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic        fetch_busy_o;

  always #5 clk = ~clk;

  fetch_stage #(.N(32), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .imem_ack_i       (imem_ack_i),
    .pc_o             (pc_o),
    .if_id_instr_o    (if_id_instr_o),
    .if_id_pc4_o      (if_id_pc4_o),
    .if_id_valid_o    (if_id_valid_o),
    .fetch_busy_o     (fetch_busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch in flight, words parked for a stalled decode,
  // and a redirect target waiting for an in-flight word to drain.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic [31:0] m_pc, m_ifi, m_ifp;
  bit          m_ifv, m_inflight, m_delivered;
  ent_t        parked[$];
  logic [31:0] pend_tgt[$];

  // Memory model
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  task automatic model_reset();
    m_pc = RESET_PC;
    m_ifi = '0;
    m_ifp = '0;
    m_ifv = 1'b0;
    m_inflight = 1'b0;
    parked.delete();
    pend_tgt.delete();
    mem_busy = 1'b0;
  endtask

  function automatic bit exp_req();
    if (reset) return 1'b0;
    if (m_inflight) return 1'b1;
    if (parked.size() != 0) return 1'b0;
    return !stall_i;
  endfunction

  task automatic model_step(input bit req);
    logic [31:0] tgt;
    ent_t e;
    tgt = redirect_pc_i & 32'hFFFF_FFFC;
    m_delivered = 1'b0;
    if (!stall_i || redirect_valid_i) begin
      m_ifv = 1'b0;
      m_ifi = '0;
    end
    if (parked.size() != 0) begin
      if (redirect_valid_i) begin
        parked.delete();
        m_pc = tgt;
      end else if (!stall_i) begin
        e = parked.pop_front();
        m_ifi = e.instr;
        m_ifp = e.pc4;
        m_ifv = 1'b1;
        m_delivered = 1'b1;
      end
    end else if (req && imem_ack_i) begin
      m_inflight = 1'b0;
      if (redirect_valid_i) begin
        pend_tgt.delete();
        m_pc = tgt;
      end else if (pend_tgt.size() != 0) begin
        m_pc = pend_tgt.pop_front();
      end else begin
        e.instr = imem_rdata_i;
        e.pc4   = m_pc + 32'd4;
        m_pc    = e.pc4;
        if (stall_i) parked.push_back(e);
        else begin
          m_ifi = e.instr;
          m_ifp = e.pc4;
          m_ifv = 1'b1;
          m_delivered = 1'b1;
        end
      end
    end else if (req) begin
      m_inflight = 1'b1;
      if (redirect_valid_i) begin
        pend_tgt.delete();
        pend_tgt.push_back(tgt);
      end
    end else if (redirect_valid_i) begin
      m_pc = tgt;
    end
  endtask

  function automatic logic [31:0] pick_target();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
    return RESET_PC + 32'($urandom_range(0, 1023));
  endfunction

  initial begin
    bit ereq;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      reset            = (cyc < 2) || ($urandom_range(0, 299) == 0);
      stall_i          = ($urandom_range(0, 3) == 0);
      redirect_valid_i = ($urandom_range(0, 7) == 0);
      redirect_pc_i    = pick_target();
      #1;
      ereq = exp_req();
      check_eq("req", 32'(imem_req_o), 32'(ereq));
      check_eq("addr", imem_addr_o, m_pc);
      if (ereq && mem_busy) check_eq("addr_stable", imem_addr_o, mem_addr);
      if (ereq) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_cnt  = $urandom_range(0, 3);
          mem_addr = m_pc;
        end
        imem_ack_i   = (mem_cnt == 0);
        imem_rdata_i = mem_addr ^ 32'h0000_FFFF ^ {mem_addr[22:0], 9'h0};
      end else begin
        imem_ack_i   = ($urandom_range(0, 7) == 0);
        imem_rdata_i = $urandom;
      end
      @(posedge clk);
      #1;
      if (reset) model_reset();
      else begin
        model_step(ereq);
        if (ereq) begin
          if (imem_ack_i) mem_busy = 1'b0;
          else mem_cnt--;
        end
      end
      check_eq("pc", pc_o, m_pc);
      check_eq("if_id_valid", 32'(if_id_valid_o), 32'(m_ifv));
      check_eq("if_id_instr", if_id_instr_o, m_ifi);
      check_eq("if_id_pc4", if_id_pc4_o, m_ifp);
      check_eq("busy", 32'(fetch_busy_o), 32'(m_inflight || (parked.size() != 0)));
      if (!reset && m_delivered)
        $display("IFID cyc=%0d instr=%h pc4=%h", cyc, m_ifi, m_ifp);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
